// File: rtl/xadc_drp_cfg_writer_pkg.sv
// Shared definitions for the XADC DRP configuration writer: register map, table entry type, FSM states.
package xadc_drp_cfg_writer_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned TMO_W  = 8;

  // XADC DRP register addresses
  localparam logic [ADDR_W-1:0] DRP_CFG0 = 7'h40;
  localparam logic [ADDR_W-1:0] DRP_CFG1 = 7'h41;
  localparam logic [ADDR_W-1:0] DRP_CFG2 = 7'h42;
  localparam logic [ADDR_W-1:0] DRP_SEQ0 = 7'h48;
  localparam logic [ADDR_W-1:0] DRP_SEQ1 = 7'h49;
  localparam logic [ADDR_W-1:0] DRP_ACQ1 = 7'h4B;

  // Aux channels 6/7/14/15 in SEQ1/ACQ1 bit positions
  localparam logic [DATA_W-1:0] AUX_6_7_14_15 = 16'hC0C0;
  // CFG1 sequencer field = continuous sequence mode
  localparam logic [DATA_W-1:0] CFG1_SEQ_CONT = 16'h2000;
  localparam logic [DATA_W-1:0] CFG1_SEQ_MASK = 16'hF000;
  localparam logic [DATA_W-1:0] FULL_MASK     = 16'hFFFF;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] mask;
  } cfg_entry_t;

  typedef enum logic [3:0] {
    ST_WAIT_RST,
    ST_WR,
    ST_WR_WAIT,
    ST_RD,
    ST_RD_WAIT,
    ST_CHECK,
    ST_FIN,
    ST_FAIL,
    ST_IDLE
  } state_e;

  function automatic cfg_entry_t mk_entry(input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] data,
                                          input logic [DATA_W-1:0] mask);
    cfg_entry_t e;
    e.addr = addr;
    e.data = data;
    e.mask = mask;
    return e;
  endfunction

endpackage

// File: rtl/xadc_drp_cfg_writer_rom.sv
// Fixed XADC configuration table: index -> {DRP address, write data, readback compare mask}.
module xadc_drp_cfg_writer_rom
  import xadc_drp_cfg_writer_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  output cfg_entry_t       entry_o
);

  // Sequencer is enabled last so it only starts once channels and settling are programmed
  always_comb begin
    entry_o = '0;
    case (idx_i)
      4'd0:    entry_o = mk_entry(DRP_CFG0, 16'h0000,      FULL_MASK);
      4'd1:    entry_o = mk_entry(DRP_CFG2, 16'h0400,      FULL_MASK);
      4'd2:    entry_o = mk_entry(DRP_SEQ0, 16'h0000,      FULL_MASK);
      4'd3:    entry_o = mk_entry(DRP_SEQ1, AUX_6_7_14_15, FULL_MASK);
      4'd4:    entry_o = mk_entry(DRP_ACQ1, AUX_6_7_14_15, FULL_MASK);
      4'd5:    entry_o = mk_entry(DRP_CFG1, CFG1_SEQ_CONT, CFG1_SEQ_MASK);
      default: entry_o = '0;
    endcase
  end

endmodule

// File: rtl/xadc_drp_cfg_writer.sv
// Writes the XADC configuration table over DRP, reads each entry back to verify, then releases the bus.
module xadc_drp_cfg_writer
  import xadc_drp_cfg_writer_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 6,
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned START_DLY   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] drp_daddr,
  output logic              drp_den,
  output logic              drp_dwe,
  output logic [DATA_W-1:0] drp_di,
  input  logic [DATA_W-1:0] drp_do,
  input  logic              drp_drdy,
  output logic              bus_own,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [IDX_W-1:0]  err_idx
);

  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT_CYC);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [TMO_W-1:0] DLY_LAST = TMO_W'(START_DLY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REGS - 1);

  state_e            state_q;
  logic [TMO_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              den_q;
  logic              dwe_q;
  logic [DATA_W-1:0] di_q;
  logic              bus_own_q;
  logic              busy_q;
  logic              done_q;
  logic              error_q;
  logic [IDX_W-1:0]  err_idx_q;

  logic [IDX_W-1:0]  rom_idx_c;
  logic [TMO_W-1:0]  tmo_inc_c;
  cfg_entry_t        ent_c;

  // CHECK looks one entry ahead so the next write's address/data can be registered with its den
  assign rom_idx_c = (state_q == ST_CHECK) ? idx_q + IDX_W'(1) : idx_q;
  assign tmo_inc_c = (cnt_q == TMO_MAX) ? cnt_q : cnt_q + TMO_W'(1);

  xadc_drp_cfg_writer_rom u_rom (
    .idx_i   (rom_idx_c),
    .entry_o (ent_c)
  );

  // Table sequencer; outputs are registered on the edge that enters the state they belong to
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_WAIT_RST;
      cnt_q     <= '0;
      idx_q     <= '0;
      rd_q      <= '0;
      exp_q     <= '0;
      daddr_q   <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      di_q      <= '0;
      bus_own_q <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      den_q <= 1'b0;
      dwe_q <= 1'b0;
      case (state_q)
        ST_WAIT_RST: begin
          if (cnt_q == DLY_LAST) begin
            state_q <= ST_WR;
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            daddr_q <= ent_c.addr;
            di_q    <= ent_c.data;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + TMO_W'(1);
          end
        end
        ST_WR: begin
          state_q <= ST_WR_WAIT;
          cnt_q   <= tmo_inc_c;
        end
        ST_WR_WAIT: begin
          if (drp_drdy) begin
            state_q <= ST_RD;
            den_q   <= 1'b1;
            cnt_q   <= '0;
          end else if (cnt_q == TMO_LAST) begin
            state_q   <= ST_FAIL;
            error_q   <= 1'b1;
            err_idx_q <= idx_q;
            busy_q    <= 1'b0;
            bus_own_q <= 1'b0;
            daddr_q   <= '0;
          end else begin
            cnt_q <= tmo_inc_c;
          end
        end
        ST_RD: begin
          state_q <= ST_RD_WAIT;
          cnt_q   <= tmo_inc_c;
          exp_q   <= ent_c.data & ent_c.mask;
        end
        ST_RD_WAIT: begin
          if (drp_drdy) begin
            state_q <= ST_CHECK;
            rd_q    <= drp_do & ent_c.mask;
          end else if (cnt_q == TMO_LAST) begin
            state_q   <= ST_FAIL;
            error_q   <= 1'b1;
            err_idx_q <= idx_q;
            busy_q    <= 1'b0;
            bus_own_q <= 1'b0;
            daddr_q   <= '0;
          end else begin
            cnt_q <= tmo_inc_c;
          end
        end
        ST_CHECK: begin
          if (rd_q != exp_q) begin
            state_q   <= ST_FAIL;
            error_q   <= 1'b1;
            err_idx_q <= idx_q;
            busy_q    <= 1'b0;
            bus_own_q <= 1'b0;
            daddr_q   <= '0;
          end else if (idx_q == IDX_LAST) begin
            state_q   <= ST_FIN;
            done_q    <= 1'b1;
            busy_q    <= 1'b0;
            bus_own_q <= 1'b0;
            daddr_q   <= '0;
          end else begin
            state_q <= ST_WR;
            idx_q   <= rom_idx_c;
            den_q   <= 1'b1;
            dwe_q   <= 1'b1;
            daddr_q <= ent_c.addr;
            di_q    <= ent_c.data;
            cnt_q   <= '0;
          end
        end
        ST_FIN, ST_FAIL: begin
          state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (start) begin
            state_q   <= ST_WAIT_RST;
            cnt_q     <= '0;
            idx_q     <= '0;
            bus_own_q <= 1'b1;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign drp_daddr = daddr_q;
  assign drp_den   = den_q;
  assign drp_dwe   = dwe_q;
  assign drp_di    = di_q;
  assign bus_own   = bus_own_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_idx   = err_idx_q;

endmodule

// File: tb/tb_xadc_drp_cfg_writer.sv
// Directed bench for xadc_drp_cfg_writer with a behavioural DRP responder (latency, storage, fault knobs).
module tb_xadc_drp_cfg_writer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [6:0]  drp_daddr;
  logic        drp_den;
  logic        drp_dwe;
  logic [15:0] drp_di;
  logic [15:0] drp_do;
  logic        drp_drdy;
  logic        bus_own;
  logic        busy;
  logic        done;
  logic        error;
  logic [3:0]  err_idx;

  int tests = 0;
  int fails = 0;

  // Responder state and fault knobs
  logic        rsp_drdy = 1'b0;
  logic        stray = 1'b0;
  logic [15:0] rsp_do = 16'h0;
  logic [15:0] mem [128];
  logic [23:0] log_q [32];
  int          log_n = 0;
  int          overlap_n = 0;
  int          pend = 0;
  logic [6:0]  pend_addr = 7'h0;
  logic        pend_we = 1'b0;
  logic        pend_drop = 1'b0;
  int          lat = 4;
  logic        corrupt_en = 1'b0;
  logic        drop_en = 1'b0;

  logic [6:0]  exp_addr [6] = '{7'h40, 7'h42, 7'h48, 7'h49, 7'h4B, 7'h41};
  logic [15:0] exp_data [6] = '{16'h0000, 16'h0400, 16'h0000, 16'hC0C0, 16'hC0C0, 16'h2000};

  assign drp_drdy = rsp_drdy | stray;
  assign drp_do   = rsp_do;

  always #5 clk = ~clk;

  xadc_drp_cfg_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .drp_daddr (drp_daddr),
    .drp_den   (drp_den),
    .drp_dwe   (drp_dwe),
    .drp_di    (drp_di),
    .drp_do    (drp_do),
    .drp_drdy  (drp_drdy),
    .bus_own   (bus_own),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .err_idx   (err_idx)
  );

  // Readback: optional bit-13 flip on SEQ0, junk in CFG1's unmasked low bits
  function automatic logic [15:0] rd_value(input logic [6:0] a);
    logic [15:0] v;
    v = mem[a];
    if (corrupt_en && a == 7'h48) v = v ^ 16'h2000;
    if (a == 7'h41) v = v | 16'h0123;
    return v;
  endfunction

  // DRP responder: fixed drdy latency after den, register storage, transaction log
  always @(negedge clk) begin
    rsp_drdy = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0 && !pend_drop) begin
        rsp_drdy = 1'b1;
        rsp_do   = pend_we ? 16'h0 : rd_value(pend_addr);
      end
    end
    if (rst === 1'b1 || (start === 1'b1 && busy === 1'b0)) begin
      log_n = 0;
    end else if (drp_den === 1'b1) begin
      if (pend > 0) overlap_n = overlap_n + 1;
      if (log_n < 32) log_q[log_n] = {drp_daddr, drp_dwe, drp_dwe ? drp_di : 16'h0};
      log_n = log_n + 1;
      if (drp_dwe) mem[drp_daddr] = drp_di;
      pend      = lat;
      pend_addr = drp_daddr;
      pend_we   = drp_dwe;
      pend_drop = drop_en && drp_dwe && (drp_daddr == 7'h40);
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_vals",
        {drp_daddr, drp_den, drp_dwe, drp_di, bus_own, busy, done, error, err_idx},
        {7'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0});
    @(posedge clk); #1 rst = 1'b0;
  endtask

  // Cycle c=0 is the first cycle in WAIT_RST; strays at c=5/10 land inside WAIT_RST
  task automatic run_seq(input int c0, input int bound, input int start_at,
                         output int den_first, output int end_cyc);
    den_first = -1;
    end_cyc   = -1;
    for (int c = c0; c < bound; c++) begin
      @(negedge clk);
      stray = (c == 5 || c == 10);
      start = (c == start_at);
      if (drp_den === 1'b1 && den_first < 0) den_first = c;
      if (busy === 1'b0) begin
        end_cyc = c;
        break;
      end
    end
    stray = 1'b0;
    start = 1'b0;
  endtask

  task automatic check_log(input string tag, input int n);
    chk({tag, "_den_count"}, 64'(log_n), 64'(n));
    for (int i = 0; i < n; i++) begin
      logic [23:0] e;
      e = {exp_addr[i/2], (i % 2 == 0), (i % 2 == 0) ? exp_data[i/2] : 16'h0};
      chk($sformatf("%s_txn%0d", tag, i), 64'(log_q[i]), 64'(e));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int den_first;
    int end_cyc;
    int found;

    // Nominal run, latency 4, stray drdy during WAIT_RST
    do_reset();
    run_seq(0, 300, -1, den_first, end_cyc);
    chk("nom_first_den", 64'(den_first), 64'(16));
    chk("nom_end_cycle", 64'(end_cyc), 64'(82));
    chk("nom_flags", {done, error, bus_own, busy, drp_den}, 5'b10000);
    check_log("nom", 12);

    // Stray drdy while IDLE
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      stray = (c % 2 == 0);
    end
    @(negedge clk);
    stray = 1'b0;
    @(negedge clk);
    chk("idle_stray_dens", 64'(log_n), 64'(12));
    chk("idle_stray_flags", {done, busy, bus_own, drp_den, drp_daddr}, {1'b1, 1'b0, 1'b0, 1'b0, 7'h0});

    // Rerun via start; second start at c=30 while busy must be ignored
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("start_flags", {done, error, busy, bus_own}, 4'b0011);
    run_seq(1, 300, 30, den_first, end_cyc);
    chk("rerun_first_den", 64'(den_first), 64'(16));
    chk("rerun_end_cycle", 64'(end_cyc), 64'(82));
    chk("rerun_flags", {done, error, bus_own, busy}, 4'b1000);
    check_log("rerun", 12);

    // Readback of entry 2 corrupted
    corrupt_en = 1'b1;
    do_reset();
    run_seq(0, 300, -1, den_first, end_cyc);
    chk("corrupt_end_cycle", 64'(end_cyc), 64'(49));
    chk("corrupt_flags", {done, error, busy, bus_own, err_idx}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd2});
    check_log("corrupt", 6);
    repeat (20) @(negedge clk);
    chk("corrupt_no_more_den", 64'(log_n), 64'(6));
    corrupt_en = 1'b0;

    // Entry 0 write never acknowledged
    drop_en = 1'b1;
    do_reset();
    run_seq(0, 600, -1, den_first, end_cyc);
    chk("tmo_first_den", 64'(den_first), 64'(16));
    chk("tmo_end_cycle", 64'(end_cyc), 64'(16 + 255));
    chk("tmo_flags", {done, error, busy, bus_own, err_idx}, {1'b0, 1'b1, 1'b0, 1'b0, 4'd0});
    chk("tmo_den_count", 64'(log_n), 64'(1));
    drop_en = 1'b0;
    repeat (8) @(negedge clk);

    // Reset pulse during RD_WAIT of entry 3, orphan drdy lands in WAIT_RST
    do_reset();
    found = -1;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (drp_den === 1'b1 && drp_dwe === 1'b0 && drp_daddr === 7'h49) begin
        found = c;
        break;
      end
    end
    chk("midrst_rd3_cycle", 64'(found), 64'(54));
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_reset_vals",
        {drp_daddr, drp_den, drp_dwe, drp_di, bus_own, busy, done, error, err_idx},
        {7'h0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0});
    run_seq(1, 300, -1, den_first, end_cyc);
    chk("midrst_first_den", 64'(den_first), 64'(16));
    chk("midrst_end_cycle", 64'(end_cyc), 64'(82));
    chk("midrst_flags", {done, error, bus_own, busy}, 4'b1000);
    check_log("midrst", 12);
    chk("no_overlapping_den", 64'(overlap_n), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
